// File: rtl/dm_responder.sv
// Word-organised data memory for the MEM stage: lane-steered stores, same-cycle extended loads,
// a sticky first-fault recorder for bad stores and a saturating committed-store counter.
module dm_responder #(
  parameter int AW    = 7,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_w,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [2:0]       dm_type,
  output logic [31:0]      rdata,
  output logic             err_valid,
  output logic [1:0]       err_cause,
  output logic [31:0]      err_addr,
  input  logic             err_clr,
  output logic [CNT_W-1:0] wr_count
);

  localparam int DEPTH = 1 << AW;

  logic [31:0]      mem_r [DEPTH];
  logic [AW-1:0]    widx_s;
  logic [1:0]       lane_s;
  logic             in_range_s;
  logic             misalign_s;
  logic             fault_s;
  logic             store_s;
  logic [3:0]       be_s;
  logic [31:0]      wlane_s;
  logic [31:0]      word_s;
  logic             err_valid_r;
  logic [1:0]       err_cause_r;
  logic [31:0]      err_addr_r;
  logic [CNT_W-1:0] wr_count_r;

  function automatic logic [3:0] byte_enable(input logic [2:0] t, input logic [1:0] lane);
    case (t)
      3'b001, 3'b010: byte_enable = 4'b0011 << lane;
      3'b011, 3'b100: byte_enable = 4'b0001 << lane;
      default:        byte_enable = 4'b1111;
    endcase
  endfunction

  // Store data is right-justified, so the low bits are copied onto every lane and masked by be.
  function automatic logic [31:0] steer_data(input logic [2:0] t, input logic [31:0] d);
    case (t)
      3'b001, 3'b010: steer_data = {2{d[15:0]}};
      3'b011, 3'b100: steer_data = {4{d[7:0]}};
      default:        steer_data = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [2:0] t,
                                               input logic [1:0] lane);
    logic [15:0] h;
    logic [7:0]  b;
    h = lane[1] ? w[31:16] : w[15:0];
    b = w[{lane, 3'b000} +: 8];
    case (t)
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b010:  load_extract = {16'h0000, h};
      3'b011:  load_extract = {{24{b[7]}}, b};
      3'b100:  load_extract = {24'h000000, b};
      default: load_extract = w;
    endcase
  endfunction

  // Address decode and store legality
  always_comb begin
    widx_s     = addr[AW+1:2];
    lane_s     = addr[1:0];
    in_range_s = (addr[31:AW+2] == {(30-AW){1'b0}});
    case (dm_type)
      3'b001, 3'b010: misalign_s = addr[0];
      3'b011, 3'b100: misalign_s = 1'b0;
      default:        misalign_s = (addr[1:0] != 2'b00);
    endcase
    fault_s = mem_w & (misalign_s | ~in_range_s);
    store_s = mem_w & ~fault_s;
    be_s    = byte_enable(dm_type, lane_s);
    wlane_s = steer_data(dm_type, wdata);
  end

  // RAM byte-lane write; contents survive reset, but a store coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (store_s && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          mem_r[widx_s][8*b +: 8] <= wlane_s[8*b +: 8];
        end
      end
    end
  end

  // Combinational load path: pre-edge contents during a same-word store
  always_comb begin
    word_s = mem_r[widx_s];
    if (reset) begin
      rdata = 32'h0000_0000;
    end else if (in_range_s) begin
      rdata = load_extract(word_s, dm_type, lane_s);
    end else begin
      rdata = 32'h0000_0000;
    end
  end

  // Fault record: first fault wins, but a fault alongside err_clr replaces the old record
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_valid_r <= 1'b0;
      err_cause_r <= 2'b00;
      err_addr_r  <= 32'h0000_0000;
    end else if (fault_s && (!err_valid_r || err_clr)) begin
      err_valid_r <= 1'b1;
      err_cause_r <= {~in_range_s, misalign_s};
      err_addr_r  <= addr;
    end else if (err_clr && !fault_s) begin
      err_valid_r <= 1'b0;
      err_cause_r <= 2'b00;
      err_addr_r  <= 32'h0000_0000;
    end else begin
      err_valid_r <= err_valid_r;
      err_cause_r <= err_cause_r;
      err_addr_r  <= err_addr_r;
    end
  end

  // Saturating count of committed stores
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count_r <= {CNT_W{1'b0}};
    end else if (store_s && (wr_count_r != {CNT_W{1'b1}})) begin
      wr_count_r <= wr_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      wr_count_r <= wr_count_r;
    end
  end

  assign err_valid = err_valid_r;
  assign err_cause = err_cause_r;
  assign err_addr  = err_addr_r;
  assign wr_count  = wr_count_r;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: a byte-addressed memory model checked every cycle, plus directed
// vectors with literal expectations. A second instance with a 4-bit counter covers saturation.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_w = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [2:0]  dm_type = 3'b000;

  logic [31:0] rdata, err_addr, rdata4, err_addr4;
  logic        err_valid, err_valid4;
  logic [1:0]  err_cause, err_cause4;
  logic [15:0] wr_count;
  logic [3:0]  wr_count4;

  int checks = 0;
  int errors = 0;

  dm_responder #(.AW(7), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .mem_w(mem_w), .addr(addr), .wdata(wdata), .dm_type(dm_type),
    .rdata(rdata), .err_valid(err_valid), .err_cause(err_cause), .err_addr(err_addr),
    .err_clr(err_clr), .wr_count(wr_count));

  dm_responder #(.AW(7), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .mem_w(mem_w), .addr(addr), .wdata(wdata), .dm_type(dm_type),
    .rdata(rdata4), .err_valid(err_valid4), .err_cause(err_cause4), .err_addr(err_addr4),
    .err_clr(err_clr), .wr_count(wr_count4));

  always #5 clk = ~clk;

  // Reference model: 512 bytes, little-endian, with a known-flag per byte
  logic [7:0]  m_mem [512];
  bit          m_known [512];
  logic        m_ev = 1'b0;
  logic [1:0]  m_cause = 2'b00;
  logic [31:0] m_addr = 32'h0;
  int          m_cnt16 = 0;
  int          m_cnt4 = 0;

  initial for (int i = 0; i < 512; i++) m_known[i] = 1'b0;

  function automatic int tsize(input logic [2:0] t);
    case (t)
      3'b001, 3'b010: return 2;
      3'b011, 3'b100: return 1;
      default:        return 4;
    endcase
  endfunction

  // Returns {all bytes known, expected load value}
  function automatic logic [32:0] model_load(input logic [31:0] a, input logic [2:0] t);
    int size;
    int base;
    logic [31:0] v;
    bit ok;
    if (a >= 32'd512) return {1'b1, 32'h0};
    size = tsize(t);
    base = int'(a) - (int'(a) % size);
    v = 32'h0;
    ok = 1'b1;
    for (int k = 0; k < size; k++) begin
      if (!m_known[base + k]) ok = 1'b0;
      v = v | (32'(m_mem[base + k]) << (8 * k));
    end
    if (t == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    if (t == 3'b011 && v[7])  v = v | 32'hFFFF_FF00;
    return {ok, v};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    int  size;
    bit  mis;
    bit  oor;
    if (reset) begin
      m_ev = 1'b0; m_cause = 2'b00; m_addr = 32'h0; m_cnt16 = 0; m_cnt4 = 0;
    end else begin
      size = tsize(dm_type);
      oor  = (addr >= 32'd512);
      mis  = (addr % size) != 0;
      if (mem_w && (mis || oor)) begin
        if (!m_ev || err_clr) begin
          m_ev = 1'b1; m_cause = {oor, mis}; m_addr = addr;
        end
      end else begin
        if (mem_w) begin
          for (int k = 0; k < size; k++) begin
            m_mem[int'(addr) + k]   = wdata[8*k +: 8];
            m_known[int'(addr) + k] = 1'b1;
          end
          if (m_cnt16 < 65535) m_cnt16++;
          if (m_cnt4 < 15) m_cnt4++;
        end
        if (err_clr) begin
          m_ev = 1'b0; m_cause = 2'b00; m_addr = 32'h0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic [32:0] r;
    r = reset ? {1'b1, 32'h0} : model_load(addr, dm_type);
    if (r[32]) begin
      chk("rdata", rdata, r[31:0]);
      chk("rdata4", rdata4, r[31:0]);
    end
    chk("err_valid", 32'(err_valid), 32'(m_ev));
    chk("err_cause", 32'(err_cause), 32'(m_cause));
    chk("err_addr", err_addr, m_addr);
    chk("wr_count", 32'(wr_count), m_cnt16);
    chk("wr_count4", 32'(wr_count4), m_cnt4);
  end

  task automatic op(input logic w, input logic [31:0] a, input logic [31:0] d,
                    input logic [2:0] t, input logic clr);
    mem_w = w; addr = a; wdata = d; dm_type = t; err_clr = clr;
    @(posedge clk);
    #1;
    mem_w = 1'b0; err_clr = 1'b0;
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] t);
    @(posedge clk);
    #1;
    addr = a; dm_type = t;
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] tlist [5];
    logic [2:0] t;
    logic [31:0] off;
    tlist[0] = 3'b000; tlist[1] = 3'b001; tlist[2] = 3'b011; tlist[3] = 3'b010; tlist[4] = 3'b100;

    repeat (2) @(posedge clk);
    #1;
    chk("rst rdata", rdata, 32'h0);
    chk("rst err_valid", 32'(err_valid), 32'h0);
    chk("rst wr_count", 32'(wr_count), 32'h0);
    reset = 1'b0;

    // 1: word store then load
    op(1'b1, 32'h10, 32'hDEADBEEF, 3'b000, 1'b0);
    ld(32'h10, 3'b000);
    chk("t1 lw", rdata, 32'hDEADBEEF);
    chk("t1 count", 32'(wr_count), 32'd1);

    // 2: byte lane steering and extension
    op(1'b1, 32'h13, 32'h000000A5, 3'b011, 1'b0);
    ld(32'h10, 3'b000); chk("t2 lw", rdata, 32'hA5ADBEEF);
    ld(32'h13, 3'b011); chk("t2 lb", rdata, 32'hFFFFFFA5);
    ld(32'h13, 3'b100); chk("t2 lbu", rdata, 32'h000000A5);

    // 3: halfword store, misaligned fault, first fault wins
    op(1'b1, 32'h12, 32'h00001234, 3'b001, 1'b0);
    ld(32'h12, 3'b001); chk("t3 lh", rdata, 32'h00001234);
    ld(32'h13, 3'b001); chk("t3 lh odd", rdata, 32'h00001234);
    ld(32'h12, 3'b000); chk("t3 lw mis", rdata, 32'h1234BEEF);
    op(1'b1, 32'h11, 32'h0000FFFF, 3'b001, 1'b0);
    chk("t3 ev", 32'(err_valid), 32'd1);
    chk("t3 cause", 32'(err_cause), 32'd1);
    chk("t3 eaddr", err_addr, 32'h11);
    ld(32'h10, 3'b000); chk("t3 nowrite", rdata, 32'h1234BEEF);
    op(1'b1, 32'h1000, 32'h0, 3'b000, 1'b0);
    chk("t3 held", err_addr, 32'h11);

    // 4: clear and new fault together, then plain clear
    op(1'b1, 32'h202, 32'h0, 3'b000, 1'b1);
    chk("t4 ev", 32'(err_valid), 32'd1);
    chk("t4 cause", 32'(err_cause), 32'd3);
    chk("t4 eaddr", err_addr, 32'h202);
    ld(32'h800, 3'b000); chk("t4 oor", rdata, 32'h0);
    op(1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
    chk("t4 clr", 32'(err_valid), 32'd0);

    // 5: fill stores to saturate the 4-bit counter
    op(1'b1, 32'h20, 32'h55AA1234, 3'b000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      t = tlist[i % 5];
      off = (t == 3'b000) ? 32'd0 : ((t == 3'b001 || t == 3'b010) ? 32'(2 * (i % 2)) : 32'(i % 4));
      op(1'b1, 32'h40 + 32'(4 * i) + off, 32'h9E3779B9 * 32'(i + 1), t, 1'b0);
      ld(32'h40 + 32'(4 * i) + off, t);
    end
    chk("t5 count16", 32'(wr_count), 32'd24);
    chk("t5 count4", 32'(wr_count4), 32'd15);
    op(1'b1, 32'h41, 32'h0, 3'b000, 1'b0);
    chk("t5 fault nocount", 32'(wr_count4), 32'd15);

    // 6: reset during a store edge
    op(1'b1, 32'h11, 32'h0, 3'b001, 1'b0);
    ld(32'h20, 3'b000); chk("t6 pre", rdata, 32'h55AA1234);
    mem_w = 1'b1; addr = 32'h20; wdata = 32'hFFFFFFFF; dm_type = 3'b000;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6 rdata rst", rdata, 32'h0);
    chk("t6 ev rst", 32'(err_valid), 32'd0);
    chk("t6 eaddr rst", err_addr, 32'h0);
    chk("t6 count rst", 32'(wr_count), 32'd0);
    @(posedge clk);
    #1;
    chk("t6 rdata held", rdata, 32'h0);
    mem_w = 1'b0;
    reset = 1'b0;
    ld(32'h20, 3'b000); chk("t6 unchanged", rdata, 32'h55AA1234);
    op(1'b1, 32'h24, 32'h01020304, 3'b000, 1'b0);
    chk("t6 count resume", 32'(wr_count), 32'd1);
    ld(32'h24, 3'b000);
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
